// File: rtl/line_bus_pkg.sv
// Shared definitions for the cache-line bus arbiter and related bus blocks:
// FSM state encoding, default address/line widths and the byte-mask width helper.
package line_bus_pkg;

  localparam int LB_AWIDTH = 32;
  localparam int LB_LWIDTH = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT_W = 2'd2,
    WAIT_R = 2'd3
  } arb_state_e;

  // One mask bit per data byte.
  function automatic int lb_mwidth(input int lw);
    return lw / 8;
  endfunction

endpackage

// File: rtl/bus_rr_pick.sv
// Combinational round-robin selector: scans the pending vector upward from
// the pointer with wrap and returns the first pending entry as a one-hot
// grant, its index and a valid flag.
module bus_rr_pick #(
  parameter  int N  = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  pend_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] idx_o,
  output logic          valid_o
);

  // First pending entry at or above the pointer wins, wrapping at N.
  always_comb begin
    int c;
    c       = 0;
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      c = (int'(ptr_i) + k) % N;
      if (!valid_o && pend_i[c]) begin
        valid_o  = 1'b1;
        grant_o[c] = 1'b1;
        idx_o    = PW'(c);
      end
    end
  end

endmodule

// File: rtl/line_bus_arb_n.sv
// N-master arbiter for the 128-bit cache-line request interface.
// Each master owns one write slot and one read slot; pulses are captured into
// the slots and one transaction at a time is issued downstream in round-robin
// order (write before read within a master). Finish/valid strobes are routed
// back to the owning master.
// Optional feature: define ARB_TIMEOUT_EN to add a watchdog that forces a
// finish to the owner after TMO_CYC cycles counted from the ISSUE cycle.
module line_bus_arb_n
  import line_bus_pkg::*;
#(
  parameter  int NMST    = 3,
  parameter  int AWIDTH  = LB_AWIDTH,
  parameter  int LWIDTH  = LB_LWIDTH,
  parameter  int TMO_CYC = 1023,
  localparam int MWIDTH  = lb_mwidth(LWIDTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NMST-1:0]          m_wstart_rq,
  input  logic [NMST*AWIDTH-1:0]   m_win_addr,
  input  logic [NMST*LWIDTH-1:0]   m_in_wdata,
  input  logic [NMST*MWIDTH-1:0]   m_in_mask,
  output logic [NMST-1:0]          m_finish_wresp,
  input  logic [NMST-1:0]          m_rstart_rq,
  input  logic [NMST*AWIDTH-1:0]   m_rin_addr,
  output logic [LWIDTH-1:0]        m_rdat_m_data,
  output logic [NMST-1:0]          m_rdat_m_valid,
  output logic [NMST-1:0]          m_finish_mrd,
  output logic [NMST-1:0]          m_ovf,
  output logic                     s_wstart_rq,
  output logic [AWIDTH-1:0]        s_win_addr,
  output logic [LWIDTH-1:0]        s_in_wdata,
  output logic [MWIDTH-1:0]        s_in_mask,
  input  logic                     s_finish_wresp,
  output logic                     s_rstart_rq,
  output logic [AWIDTH-1:0]        s_rin_addr,
  input  logic [LWIDTH-1:0]        s_rdat_m_data,
  input  logic                     s_rdat_m_valid,
  input  logic                     s_finish_mrd,
  output logic                     arb_err
);

  localparam int PW = (NMST > 1) ? $clog2(NMST) : 1;

  if (NMST < 2 || NMST > 8 || TMO_CYC < 1) begin : g_badCfg
    $error("line_bus_arb_n: NMST must be 2..8 and TMO_CYC positive");
  end

  arb_state_e        state_q;
  logic [PW-1:0]     owner_q, ptr_q, nextPtr, pickIdx;
  logic [NMST-1:0]   wPend_q, rPend_q, wPend_d, rPend_d, ovf_q, ovf_d;
  logic [NMST-1:0]   wBusy, rBusy, wCap, rCap, wClr, rClr, ownerHot, pickGrant;
  logic              pickValid, wDone, rDone, tmoHit, errSet, err_q;
  logic              wStart_q, rStart_q;
  logic [AWIDTH-1:0] sWaddr_q, sRaddr_q;
  logic [LWIDTH-1:0] sWdata_q;
  logic [MWIDTH-1:0] sWmask_q;

  logic [AWIDTH-1:0] slotWaddr [NMST];
  logic [LWIDTH-1:0] slotWdata [NMST];
  logic [MWIDTH-1:0] slotWmask [NMST];
  logic [AWIDTH-1:0] slotRaddr [NMST];

  bus_rr_pick #(.N(NMST)) uPick (
    .pend_i  (wPend_q | rPend_q),
    .ptr_i   (ptr_q),
    .grant_o (pickGrant),
    .idx_o   (pickIdx),
    .valid_o (pickValid)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int TW = ($clog2(TMO_CYC + 1) > 10) ? $clog2(TMO_CYC + 1) : 10;
  logic [TW-1:0] tmo_q;

  // Watchdog counts from the ISSUE cycle; it is held at zero while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               tmo_q <= '0;
    else if (state_q == IDLE) tmo_q <= '0;
    else if (!tmoHit)         tmo_q <= tmo_q + 1'b1;
  end

  assign tmoHit = ((state_q == WAIT_W) || (state_q == WAIT_R)) && (tmo_q == TW'(TMO_CYC));
`else
  assign tmoHit = 1'b0;
`endif

  assign ownerHot = NMST'(1) << owner_q;
  assign nextPtr  = (owner_q == PW'(NMST - 1)) ? '0 : owner_q + 1'b1;
  assign wDone    = (state_q == WAIT_W) && (s_finish_wresp || tmoHit);
  assign rDone    = (state_q == WAIT_R) && (s_finish_mrd || tmoHit);
  assign wClr     = wDone ? ownerHot : '0;
  assign rClr     = rDone ? ownerHot : '0;
  assign errSet   = (s_finish_wresp && (state_q != WAIT_W)) ||
                    (s_finish_mrd && (state_q != WAIT_R)) || tmoHit;

  // A slot being cleared this cycle is free, so a same-cycle pulse is captured.
  assign wBusy   = wPend_q & ~wClr;
  assign rBusy   = rPend_q & ~rClr;
  assign wCap    = m_wstart_rq & ~wBusy;
  assign rCap    = m_rstart_rq & ~rBusy;
  assign wPend_d = wCap | wBusy;
  assign rPend_d = rCap | rBusy;
  assign ovf_d   = ovf_q | (m_wstart_rq & wBusy) | (m_rstart_rq & rBusy);

  // Slot occupancy plus the sticky overflow and error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wPend_q <= '0;
      rPend_q <= '0;
      ovf_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      wPend_q <= wPend_d;
      rPend_q <= rPend_d;
      ovf_q   <= ovf_d;
      err_q   <= err_q | errSet;
    end
  end

  // Slot payload storage; only meaningful while the matching pending bit is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NMST; i++) begin
      if (wCap[i]) begin
        slotWaddr[i] <= m_win_addr[i*AWIDTH +: AWIDTH];
        slotWdata[i] <= m_in_wdata[i*LWIDTH +: LWIDTH];
        slotWmask[i] <= m_in_mask[i*MWIDTH +: MWIDTH];
      end
      if (rCap[i]) slotRaddr[i] <= m_rin_addr[i*AWIDTH +: AWIDTH];
    end
  end

  // Transaction FSM: pick, issue a one-cycle start, wait for finish, advance pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      ptr_q    <= '0;
      wStart_q <= 1'b0;
      rStart_q <= 1'b0;
      sWaddr_q <= '0;
      sWdata_q <= '0;
      sWmask_q <= '0;
      sRaddr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pickValid) begin
            owner_q <= pickIdx;
            state_q <= ISSUE;
            if (wPend_q[pickIdx]) begin
              wStart_q <= 1'b1;
              sWaddr_q <= slotWaddr[pickIdx];
              sWdata_q <= slotWdata[pickIdx];
              sWmask_q <= slotWmask[pickIdx];
            end else begin
              rStart_q <= 1'b1;
              sRaddr_q <= slotRaddr[pickIdx];
            end
          end
        end
        ISSUE: begin
          wStart_q <= 1'b0;
          rStart_q <= 1'b0;
          state_q  <= wStart_q ? WAIT_W : WAIT_R;
        end
        WAIT_W: begin
          if (wDone) begin
            ptr_q   <= nextPtr;
            state_q <= IDLE;
          end
        end
        WAIT_R: begin
          if (rDone) begin
            ptr_q   <= nextPtr;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_wstart_rq    = wStart_q;
  assign s_win_addr     = sWaddr_q;
  assign s_in_wdata     = sWdata_q;
  assign s_in_mask      = sWmask_q;
  assign s_rstart_rq    = rStart_q;
  assign s_rin_addr     = sRaddr_q;
  assign m_finish_wresp = wClr;
  assign m_finish_mrd   = rClr;
  assign m_rdat_m_valid = ((state_q == WAIT_R) && s_rdat_m_valid) ? ownerHot : '0;
  assign m_rdat_m_data  = s_rdat_m_data;
  assign m_ovf          = ovf_q;
  assign arb_err        = err_q;

endmodule

// File: tb/tb_line_bus_arb_n.sv
// Self-checking bench for line_bus_arb_n (3 masters, TMO_CYC=15).
// Expected downstream transactions are queued when requests are driven and
// compared in order against what the monitor observes on the downstream port.
module tb_line_bus_arb_n;

  localparam int NMST = 3, AW = 32, LW = 128, MW = 16, TMO = 15;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [NMST-1:0]    m_wstart_rq, m_rstart_rq, m_finish_wresp, m_rdat_m_valid, m_finish_mrd, m_ovf;
  logic [NMST*AW-1:0] m_win_addr, m_rin_addr;
  logic [NMST*LW-1:0] m_in_wdata;
  logic [NMST*MW-1:0] m_in_mask;
  logic [LW-1:0]      m_rdat_m_data, s_in_wdata, s_rdat_m_data;
  logic               s_wstart_rq, s_rstart_rq, s_finish_wresp, s_rdat_m_valid, s_finish_mrd, arb_err;
  logic [AW-1:0]      s_win_addr, s_rin_addr;
  logic [MW-1:0]      s_in_mask;

  line_bus_arb_n #(.NMST(NMST), .AWIDTH(AW), .LWIDTH(LW), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_wstart_rq(m_wstart_rq), .m_win_addr(m_win_addr), .m_in_wdata(m_in_wdata),
    .m_in_mask(m_in_mask), .m_finish_wresp(m_finish_wresp),
    .m_rstart_rq(m_rstart_rq), .m_rin_addr(m_rin_addr),
    .m_rdat_m_data(m_rdat_m_data), .m_rdat_m_valid(m_rdat_m_valid),
    .m_finish_mrd(m_finish_mrd), .m_ovf(m_ovf),
    .s_wstart_rq(s_wstart_rq), .s_win_addr(s_win_addr), .s_in_wdata(s_in_wdata),
    .s_in_mask(s_in_mask), .s_finish_wresp(s_finish_wresp),
    .s_rstart_rq(s_rstart_rq), .s_rin_addr(s_rin_addr),
    .s_rdat_m_data(s_rdat_m_data), .s_rdat_m_valid(s_rdat_m_valid),
    .s_finish_mrd(s_finish_mrd), .arb_err(arb_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          isw;
    logic [31:0] addr;
    logic [127:0] data;
    logic [15:0] mask;
    int          cyc;
  } txn_t;

  typedef struct {
    int          m;
    bit          isw;
    logic [31:0] addr;
    logic [127:0] data;
    logic [15:0] mask;
    logic [2:0]  expHot;
  } vec_t;

  txn_t expQ[$];
  txn_t gotQ[$];
  vec_t vecs[5];

  int checks = 0, failures = 0;
  int pulseCyc = 0, lastFinCyc = 0, lastIssueCyc = 0;

  // Record every downstream start pulse as an observed transaction.
  always @(negedge clk) begin
    if (rst_n && (s_wstart_rq || s_rstart_rq))
      gotQ.push_back('{s_wstart_rq, (s_wstart_rq ? s_win_addr : s_rin_addr), s_in_wdata, s_in_mask, cyc});
  end

  // Hard stop in case something upstream of the bounded waits hangs.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic setW(input int m, input logic [31:0] a, input logic [127:0] d, input logic [15:0] k);
    m_wstart_rq[m] = 1'b1;
    m_win_addr[m*AW +: AW] = a;
    m_in_wdata[m*LW +: LW] = d;
    m_in_mask[m*MW +: MW]  = k;
  endtask

  task automatic setR(input int m, input logic [31:0] a);
    m_rstart_rq[m] = 1'b1;
    m_rin_addr[m*AW +: AW] = a;
  endtask

  task automatic pushExp(input bit isw, input logic [31:0] a, input logic [127:0] d, input logic [15:0] k);
    expQ.push_back('{isw, a, d, k, 0});
  endtask

  task automatic applyStimulus();
    pulseCyc = cyc;
    tick();
    m_wstart_rq = '0;
    m_rstart_rq = '0;
  endtask

  task automatic checkIssue(input string name, input int expLat, input int refCyc);
    txn_t g, e;
    int k;
    k = 0;
    while (gotQ.size() == 0 && k < 30) begin
      tick();
      k++;
    end
    if (gotQ.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_issue actual=none required=start", name);
      if (expQ.size() > 0) void'(expQ.pop_front());
      return;
    end
    g = gotQ.pop_front();
    lastIssueCyc = g.cyc;
    if (expQ.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_unexpected actual=%0h required=none", name, g.addr);
      return;
    end
    e = expQ.pop_front();
    checkOutput({name, "_type"}, g.isw, e.isw);
    checkOutput({name, "_addr"}, g.addr, e.addr);
    if (e.isw) begin
      checkOutput({name, "_data"}, g.data, e.data);
      checkOutput({name, "_mask"}, g.mask, e.mask);
    end
    if (expLat >= 0) checkOutput({name, "_lat"}, g.cyc - refCyc, expLat);
  endtask

  task automatic finishW(input logic [2:0] hot, input string name);
    s_finish_wresp = 1'b1;
    lastFinCyc = cyc;
    @(negedge clk);
    checkOutput(name, m_finish_wresp, hot);
    tick();
    s_finish_wresp = 1'b0;
  endtask

  task automatic finishR(input logic [2:0] hot, input string name);
    s_finish_mrd = 1'b1;
    lastFinCyc = cyc;
    @(negedge clk);
    checkOutput(name, m_finish_mrd, hot);
    tick();
    s_finish_mrd = 1'b0;
  endtask

  task automatic readBeat(input logic [2:0] hot, input logic [127:0] d, input string name);
    s_rdat_m_valid = 1'b1;
    s_rdat_m_data  = d;
    @(negedge clk);
    checkOutput({name, "_rvalid"}, m_rdat_m_valid, hot);
    checkOutput({name, "_rdata"}, m_rdat_m_data, d);
    tick();
    s_rdat_m_valid = 1'b0;
  endtask

  initial begin
    bit found;
    int hitCyc;
    logic [2:0] hitVal;

    m_wstart_rq = '0; m_rstart_rq = '0; m_win_addr = '0; m_rin_addr = '0;
    m_in_wdata = '0; m_in_mask = '0;
    s_finish_wresp = 1'b0; s_finish_mrd = 1'b0; s_rdat_m_valid = 1'b0; s_rdat_m_data = '0;

    vecs[0] = '{1, 1'b1, 32'h0000_1000, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210, 16'h0000, 3'b010};
    vecs[1] = '{0, 1'b0, 32'h0000_2000, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 16'h0000, 3'b001};
    vecs[2] = '{0, 1'b1, 32'hA5A5_0000, 128'hdead_beef_0000_0000_cafe_f00d_0000_0001, 16'h00FF, 3'b001};
    vecs[3] = '{2, 1'b1, 32'hFFFF_FFF0, {128{1'b1}}, 16'hFFFF, 3'b100};
    vecs[4] = '{2, 1'b0, 32'h8000_0040, 128'h8000_0000_0000_0000_0000_0000_0000_0001, 16'h0000, 3'b100};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_starts", {s_wstart_rq, s_rstart_rq}, 2'b00);
    checkOutput("rst_addr", {s_win_addr, s_rin_addr}, 64'h0);
    checkOutput("rst_flags", {m_ovf, arb_err}, 4'h0);
    checkOutput("rst_strobes", {m_finish_wresp, m_finish_mrd, m_rdat_m_valid}, 9'h0);
    rst_n = 1'b1;
    tick();

    // Table: single-master transactions, 2-cycle issue latency, owner-only strobes.
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].isw) begin
        setW(vecs[i].m, vecs[i].addr, vecs[i].data, vecs[i].mask);
        pushExp(1'b1, vecs[i].addr, vecs[i].data, vecs[i].mask);
      end else begin
        setR(vecs[i].m, vecs[i].addr);
        pushExp(1'b0, vecs[i].addr, '0, '0);
      end
      applyStimulus();
      checkIssue($sformatf("vec%0d", i), 2, pulseCyc);
      if (vecs[i].isw) begin
        finishW(vecs[i].expHot, $sformatf("vec%0d_finw", i));
      end else begin
        readBeat(vecs[i].expHot, vecs[i].data, $sformatf("vec%0d", i));
        finishR(vecs[i].expHot, $sformatf("vec%0d_finr", i));
      end
    end

    // Round robin from pointer 0; repeat requests while master 1 is active.
    setR(0, 32'h100); setR(1, 32'h200); setR(2, 32'h300);
    pushExp(1'b0, 32'h100, '0, '0);
    pushExp(1'b0, 32'h200, '0, '0);
    applyStimulus();
    checkIssue("rr0", 2, pulseCyc);
    finishR(3'b001, "rr0_fin");
    checkIssue("rr1", 2, lastFinCyc);
    setR(0, 32'h400);
    setW(2, 32'h500, 128'h5555, 16'h0F0F);
    pushExp(1'b1, 32'h500, 128'h5555, 16'h0F0F);
    pushExp(1'b0, 32'h400, '0, '0);
    pushExp(1'b0, 32'h300, '0, '0);
    applyStimulus();
    finishR(3'b010, "rr1_fin");
    checkIssue("rr2", 2, lastFinCyc);
    finishW(3'b100, "rr2_fin");
    checkIssue("rr3", -1, 0);
    finishR(3'b001, "rr3_fin");
    checkIssue("rr4", -1, 0);
    finishR(3'b100, "rr4_fin");

    // Master 0 write+read together: write first, read after master 1.
    setW(0, 32'h600, 128'h6666_0000_6666, 16'h00F0);
    setR(0, 32'h700);
    setR(1, 32'h800);
    pushExp(1'b1, 32'h600, 128'h6666_0000_6666, 16'h00F0);
    pushExp(1'b0, 32'h800, '0, '0);
    pushExp(1'b0, 32'h700, '0, '0);
    applyStimulus();
    checkIssue("wr0", 2, pulseCyc);
    finishW(3'b001, "wr0_fin");
    checkIssue("wr1", -1, 0);
    readBeat(3'b010, 128'h8888, "wr1");
    finishR(3'b010, "wr1_fin");
    checkIssue("wr2", -1, 0);
    readBeat(3'b001, 128'h7777, "wr2");
    finishR(3'b001, "wr2_fin");

    // Overflow: second write pulse on a pending slot is dropped and flagged.
    checkOutput("ovf_pre", m_ovf, 3'b000);
    setW(2, 32'hA000, 128'hAAAA, 16'h0000);
    pushExp(1'b1, 32'hA000, 128'hAAAA, 16'h0000);
    applyStimulus();
    setW(2, 32'hB000, 128'hBBBB, 16'hFFFF);
    applyStimulus();
    checkOutput("ovf_set", m_ovf, 3'b100);
    checkIssue("ovf_iss", -1, 0);
    finishW(3'b100, "ovf_fin");

    // Owner's own pulse in its finish cycle is captured, not an overflow.
    setW(1, 32'hC000, 128'hCCCC, 16'h1234);
    pushExp(1'b1, 32'hC000, 128'hCCCC, 16'h1234);
    applyStimulus();
    checkIssue("cw0", 2, pulseCyc);
    setW(1, 32'hD000, 128'hDDDD, 16'h4321);
    pushExp(1'b1, 32'hD000, 128'hDDDD, 16'h4321);
    finishW(3'b010, "cw0_fin");
    m_wstart_rq = '0;
    checkIssue("cw1", 2, lastFinCyc);
    checkOutput("cw_ovf", m_ovf, 3'b100);
    finishW(3'b010, "cw1_fin");

    // Spurious read finish while idle.
    checkOutput("err_pre", arb_err, 1'b0);
    s_finish_mrd = 1'b1;
    @(negedge clk);
    checkOutput("spur_fin", m_finish_mrd, 3'b000);
    tick();
    s_finish_mrd = 1'b0;
    checkOutput("spur_err", arb_err, 1'b1);

`ifdef ARB_TIMEOUT_EN
    // Watchdog: no finish, owner gets forced finish TMO cycles after ISSUE.
    setR(0, 32'hE000);
    pushExp(1'b0, 32'hE000, '0, '0);
    applyStimulus();
    checkIssue("tmo_iss", 2, pulseCyc);
    found = 1'b0; hitCyc = 0; hitVal = '0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (m_finish_mrd != '0) begin
        found = 1'b1;
        hitCyc = cyc;
        hitVal = m_finish_mrd;
      end
    end
    checkOutput("tmo_hot", hitVal, 3'b001);
    checkOutput("tmo_lat", hitCyc - lastIssueCyc, TMO);
    tick();
    checkOutput("tmo_err", arb_err, 1'b1);
`endif

    // Reset during WAIT_R: everything drops at once, no finish pulse.
    setR(1, 32'hF000);
    pushExp(1'b0, 32'hF000, '0, '0);
    applyStimulus();
    checkIssue("rst_iss", 2, pulseCyc);
    s_rdat_m_valid = 1'b1;
    @(negedge clk);
    checkOutput("rst_pre_valid", m_rdat_m_valid, 3'b010);
    #1;
    rst_n = 1'b0;
    s_finish_mrd = 1'b1;
    #1;
    checkOutput("rst_mid_strobes", {m_rdat_m_valid, m_finish_mrd, m_finish_wresp}, 9'h0);
    checkOutput("rst_mid_down", {s_rstart_rq, s_wstart_rq, s_rin_addr}, 34'h0);
    checkOutput("rst_mid_flags", {m_ovf, arb_err}, 4'h0);
    tick();
    s_rdat_m_valid = 1'b0;
    s_finish_mrd = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    setR(2, 32'h1100);
    setR(0, 32'h2200);
    pushExp(1'b0, 32'h2200, '0, '0);
    pushExp(1'b0, 32'h1100, '0, '0);
    applyStimulus();
    checkIssue("post0", 2, pulseCyc);
    finishR(3'b001, "post0_fin");
    checkIssue("post1", 2, lastFinCyc);
    finishR(3'b100, "post1_fin");

    repeat (5) tick();
    checkOutput("post_err", arb_err, 1'b0);
    checkOutput("exp_left", expQ.size(), 0);
    checkOutput("got_left", gotQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
